// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock qualification and ordered sys/cpu reset release.
// All outputs are registered and decoded from the next state.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int CPU_DELAY      = 256,
   parameter int CNT_W          = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       cpu_rst,
   output logic       ready,
   output logic       lock_lost,
   output logic [3:0] retry_cnt
);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_SYS_REL,
      S_RUN
   } state_t;

   localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_DELAY - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             sync1;
   logic             lock_s;
   logic             retry_inc;
   logic             lost_n;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= S_PLL_RST;
         cnt       <= '0;
         sync1     <= 1'b0;
         lock_s    <= 1'b0;
         retry_cnt <= 4'd0;
         lock_lost <= 1'b0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         cpu_rst   <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sync1     <= locked;
         lock_s    <= sync1;
         lock_lost <= lost_n;
         if (retry_inc && retry_cnt != 4'd15)
            retry_cnt <= retry_cnt + 4'd1;
         pll_rst   <= (state_n == S_PLL_RST);
         sys_rst   <= !(state_n == S_SYS_REL || state_n == S_RUN);
         cpu_rst   <= (state_n != S_RUN);
         ready     <= (state_n == S_RUN);
      end
   end

   // Lock loss is tested before any terminal count so it always wins.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      retry_inc = 1'b0;
      lost_n    = 1'b0;
      unique case (state)
         S_PLL_RST: begin
            if (cnt == PLL_LAST) begin
               state_n = S_WAIT_LOCK;
               cnt_n   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_n = S_STABLE;
               cnt_n   = '0;
            end else if (cnt == TO_LAST) begin
               state_n   = S_PLL_RST;
               cnt_n     = '0;
               retry_inc = 1'b1;
            end
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_n = S_WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == STB_LAST) begin
               state_n = S_SYS_REL;
               cnt_n   = '0;
            end
         end
         S_SYS_REL: begin
            if (!lock_s) begin
               state_n = S_WAIT_LOCK;
               cnt_n   = '0;
               lost_n  = 1'b1;
            end else if (cnt == CPU_LAST) begin
               state_n = S_RUN;
               cnt_n   = '0;
            end
         end
         S_RUN: begin
            cnt_n = '0;
            if (!lock_s) begin
               state_n = S_WAIT_LOCK;
               lost_n  = 1'b1;
            end
         end
         default: begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected event timings and
// output snapshots are queued with the stimulus and popped on observation.
module tb_pll_reset_sequencer;

   localparam int SEL_PLL  = 0;
   localparam int SEL_SYS  = 1;
   localparam int SEL_CPU  = 2;
   localparam int SEL_LOST = 3;

   // {pll_rst, sys_rst, cpu_rst, ready, lock_lost, retry_cnt}
   localparam int SNAP_RST  = 9'b1_1100_0000;
   localparam int SNAP_RUN  = 9'b0_0010_0000;
   localparam int SNAP_LOST = 9'b0_1101_0000;

   typedef struct {
      string name;
      int    val;
   } exp_t;

   logic       refclk = 1'b0;
   logic       rst;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       cpu_rst;
   logic       ready;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .CPU_DELAY     (5),
      .CNT_W         (8)
   ) dut (
      .refclk   (refclk),
      .rst      (rst),
      .locked   (locked),
      .pll_rst  (pll_rst),
      .sys_rst  (sys_rst),
      .cpu_rst  (cpu_rst),
      .ready    (ready),
      .lock_lost(lock_lost),
      .retry_cnt(retry_cnt)
   );

   always #5 refclk = ~refclk;

   always @(negedge refclk) begin
      if (mon_en) begin
         checks++;
         assert (cpu_rst || !sys_rst) else begin
            failures++;
            $display("FAIL inv_cpu_sys cpu_rst=%b sys_rst=%b t=%0t",
                     cpu_rst, sys_rst, $time);
         end
         checks++;
         assert (ready == !cpu_rst) else begin
            failures++;
            $display("FAIL inv_ready ready=%b cpu_rst=%b t=%0t",
                     ready, cpu_rst, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge refclk);
   endtask

   function automatic int snap();
      return int'({pll_rst, sys_rst, cpu_rst, ready, lock_lost, retry_cnt});
   endfunction

   function automatic logic pick(input int sel);
      case (sel)
         SEL_PLL:  return pll_rst;
         SEL_SYS:  return sys_rst;
         SEL_CPU:  return cpu_rst;
         SEL_LOST: return lock_lost;
         default:  return ready;
      endcase
   endfunction

   // Ticks until the selected output reads val; -1 if the bound expires.
   task automatic count_until(input int sel, input logic val,
                              input int lim, output int n);
      logic s;
      n = 0;
      do begin
         tick();
         n++;
         s = pick(sel);
      end while (s !== val && n < lim);
      if (s !== val) n = -1;
   endtask

   task automatic apply_reset(input logic lk);
      rst    = 1'b1;
      locked = lk;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      int   n;
      rst    = 1'b1;
      locked = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{name: "rst_outputs", val: SNAP_RST});
         tick();
         mon_en = 1'b1;
         e = sb.pop_front();
         checks++;
         if (snap() !== e.val) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", e.name, snap(), e.val);
         end
      end
      rst = 1'b0;
      sb.push_back('{name: "pll_rst_width", val: 4});
      count_until(SEL_PLL, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
   endtask

   task automatic test_release();
      exp_t e;
      int   n;
      locked = 1'b1;
      sb.push_back('{name: "sys_rst_fall", val: 11});
      sb.push_back('{name: "cpu_rst_fall", val: 5});
      sb.push_back('{name: "run_outputs", val: SNAP_RUN});
      count_until(SEL_SYS, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
      count_until(SEL_CPU, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
      e = sb.pop_front();
      checks++;
      if (snap() !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", e.name, snap(), e.val);
      end
   endtask

   task automatic test_retry();
      exp_t e;
      int   n;
      int   w;
      apply_reset(1'b0);
      count_until(SEL_PLL, 1'b0, 40, w);
      for (int i = 1; i <= 17; i++) begin
         sb.push_back('{name: "retry_period", val: 24});
         sb.push_back('{name: "retry_cnt", val: (i > 15) ? 15 : i});
         sb.push_back('{name: "retry_width", val: 4});
         count_until(SEL_PLL, 1'b1, 40, n);
         e = sb.pop_front();
         checks++;
         if ((n < 0 ? -1 : w + n) !== e.val) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", e.name, w + n, e.val);
         end
         e = sb.pop_front();
         checks++;
         if (int'(retry_cnt) !== e.val) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", e.name, retry_cnt, e.val);
         end
         count_until(SEL_PLL, 1'b0, 40, w);
         e = sb.pop_front();
         checks++;
         if (w !== e.val) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", e.name, w, e.val);
         end
      end
   endtask

   task automatic test_glitch();
      exp_t e;
      int   n;
      rst    = 1'b1;
      locked = 1'b1;
      repeat (3) tick();
      sb.push_back('{name: "retry_cleared", val: SNAP_RST});
      e = sb.pop_front();
      checks++;
      if (snap() !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", e.name, snap(), e.val);
      end
      rst = 1'b0;
      repeat (8) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      sb.push_back('{name: "glitch_sys_fall", val: 11});
      sb.push_back('{name: "glitch_cpu_fall", val: 5});
      count_until(SEL_SYS, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
      count_until(SEL_CPU, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
   endtask

   task automatic test_lock_loss();
      exp_t e;
      int   n;
      int   pll_seen;
      int   lost_seen;
      locked = 1'b0;
      sb.push_back('{name: "lost_latency", val: 3});
      sb.push_back('{name: "lost_outputs", val: SNAP_LOST});
      count_until(SEL_LOST, 1'b1, 20, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
      e = sb.pop_front();
      checks++;
      if (snap() !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", e.name, snap(), e.val);
      end
      locked = 1'b1;
      sb.push_back('{name: "relock_sys_fall", val: 11});
      sb.push_back('{name: "relock_pll_pulses", val: 0});
      sb.push_back('{name: "relock_extra_lost", val: 0});
      sb.push_back('{name: "relock_cpu_fall", val: 5});
      n         = 0;
      pll_seen  = 0;
      lost_seen = 0;
      do begin
         tick();
         n++;
         if (pll_rst) pll_seen++;
         if (lock_lost) lost_seen++;
      end while (sys_rst !== 1'b0 && n < 40);
      if (sys_rst !== 1'b0) n = -1;
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
      e = sb.pop_front();
      checks++;
      if (pll_seen !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, pll_seen, e.val);
      end
      e = sb.pop_front();
      checks++;
      if (lost_seen !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, lost_seen, e.val);
      end
      count_until(SEL_CPU, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
   endtask

   task automatic test_rst_in_sys_rel();
      exp_t e;
      int   n;
      apply_reset(1'b1);
      sb.push_back('{name: "fresh_sys_fall", val: 13});
      count_until(SEL_SYS, 1'b0, 40, n);
      e = sb.pop_front();
      checks++;
      if (n !== e.val) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", e.name, n, e.val);
      end
      repeat (2) tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{name: "rst_in_sys_rel", val: SNAP_RST});
         tick();
         e = sb.pop_front();
         checks++;
         if (snap() !== e.val) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", e.name, snap(), e.val);
         end
      end
      rst = 1'b0;
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL sb_drain actual=%0d expected=0", sb.size());
      end
   endtask

   initial begin
      rst    = 1'b1;
      locked = 1'b0;
      test_reset();
      test_release();
      test_retry();
      test_glitch();
      test_lock_loss();
      test_rst_in_sys_rel();
      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
